seq_divider: RTL and testbench

- Multi-cycle restoring divider serving MIPS DIV/DIVU. The inverse arithmetic unit to the Booth multiplier.
- Sits beside the multiplier in the execute stage. Writes the HI/LO pair: remainder to HI, quotient to LO.
- The control unit drives it with a one-cycle start pulse and waits for a one-cycle done pulse, the same handshake as the multiplier.

---
 rtl/div_pkg.sv | 19 +
 rtl/seq_divider_if.sv | 32 +++
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (MIPS DIV/DIVU).
// Contents:
//   DIV_WIDTH   default operand/quotient/remainder width
//   DIV_CNT_W   step-counter width for the default width, clog2(WIDTH+1)
//   div_state_t FSM state type, with state constants IDLE/INIT/RUN/FIX/ZERO
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef logic [2:0] div_state_t;

  localparam div_state_t IDLE = 3'd0;
  localparam div_state_t INIT = 3'd1;
  localparam div_state_t RUN  = 3'd2;
  localparam div_state_t FIX  = 3'd3;
  localparam div_state_t ZERO = 3'd4;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the control unit and
// the divider.
//   master (control unit): drives DivIn, Signed, A, B; receives the results
//   slave  (divider)     : receives DivIn, Signed, A, B; drives resultHigh
//                          (remainder, to HI), resultLow (quotient, to LO),
//                          DivOut (one-cycle done pulse) and DivZero
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             DivIn;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] resultHigh;
  logic [WIDTH-1:0] resultLow;
  logic             DivOut;
  logic             DivZero;

  modport master (
    output DivIn, Signed, A, B,
    input  resultHigh, resultLow, DivOut, DivZero
  );

  modport slave (
    input  DivIn, Signed, A, B,
    output resultHigh, resultLow, DivOut, DivZero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   i_rem, i_quo : partial remainder and quotient/dividend shift register
//   i_divisor    : divisor magnitude
//   o_rem, o_quo : state after shifting {rem,quo} left and trying a subtract
// Requires WIDTH >= 2.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    // rem < divisor always holds, so the difference fits in WIDTH+1 signed bits.
    w_trial  = w_rem_sh - {1'b0, i_divisor};
    o_quo    = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    if (!w_trial[WIDTH]) begin
      o_rem = w_trial[WIDTH-1:0];
    end else begin
      o_rem = w_rem_sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. Remainder goes to HI
// (resultHigh), quotient to LO (resultLow).
// Ports:
//   clk    clock
//   Reset  synchronous, active-high reset
//   div_if slave side of seq_divider_if (DivIn/Signed/A/B in,
//          resultHigh/resultLow/DivOut/DivZero out)
// Timing: DivIn sampled on edge 0, first step on edge 1, results and DivOut
// written on edge WIDTH+1. Divide by zero completes on edge 1.
// Build option: DIV_EARLY_TERM_EN finishes on edge 2 when |A| < |B|.
// DivIn in any state restarts with the new operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic        clk,
  input logic        Reset,
  seq_divider_if.slave div_if
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CntW-1:0]  r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_done;
  logic             r_zero;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last_step;

  // Negation wraps, so the most negative value keeps its bit pattern and
  // reads correctly as an unsigned magnitude.
  assign w_mag_a = (div_if.Signed && div_if.A[WIDTH-1]) ? -div_if.A : div_if.A;
  assign w_mag_b = (div_if.Signed && div_if.B[WIDTH-1]) ? -div_if.B : div_if.B;

  assign w_last_step = (r_cnt == CntW'(1));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_div),
    .o_rem    (w_rem_nxt),
    .o_quo    (w_quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (div_if.DivIn) begin
        r_state <= INIT;
        r_rem   <= '0;
        r_quo   <= w_mag_a;
        r_div   <= w_mag_b;
        r_cnt   <= CntW'(WIDTH);
        r_neg_q <= div_if.Signed & (div_if.A[WIDTH-1] ^ div_if.B[WIDTH-1]);
        r_neg_r <= div_if.Signed & div_if.A[WIDTH-1];
      end else begin
        case (r_state)
          INIT: begin
            if (r_div == '0) begin
              // r_quo still holds |A|; re-applying the remainder sign gives raw A.
              r_res_hi <= r_neg_r ? -r_quo : r_quo;
              r_res_lo <= '1;
              r_zero   <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= ZERO;
`ifdef DIV_EARLY_TERM_EN
            end else if (r_quo < r_div) begin
              r_rem   <= r_quo;
              r_quo   <= '0;
              r_state <= FIX;
`endif
            end else begin
              r_rem   <= w_rem_nxt;
              r_quo   <= w_quo_nxt;
              r_cnt   <= r_cnt - CntW'(1);
              r_state <= w_last_step ? FIX : RUN;
            end
          end
          RUN: begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_cnt   <= r_cnt - CntW'(1);
            r_state <= w_last_step ? FIX : RUN;
          end
          FIX: begin
            r_res_lo <= r_neg_q ? -r_quo : r_quo;
            r_res_hi <= r_neg_r ? -r_rem : r_rem;
            r_zero   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
          ZERO:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign div_if.resultHigh = r_res_hi;
  assign div_if.resultLow  = r_res_lo;
  assign div_if.DivOut     = r_done;
  assign div_if.DivZero    = r_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;

  localparam int unsigned W = 32;
`ifdef DIV_EARLY_TERM_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 33;
`endif

  logic clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  seq_divider_if #(.WIDTH(W)) div_if ();

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .div_if(div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following the edge that sampled DivIn (edge 0).
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    div_if.A      = a;
    div_if.B      = b;
    div_if.Signed = s;
    div_if.DivIn  = 1'b1;
    @(negedge clk);
    div_if.DivIn  = 1'b0;
  endtask

  // Edge index (after start) whose result makes DivOut visible; -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    if (div_if.DivOut) begin
      edges = 0;
      return;
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (div_if.DivOut) begin
        edges = n;
        return;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_zero, input int exp_lat);
    int edges;
    start(a, b, s);
    wait_done(edges);
    check_eq({tag, "_lat"}, edges, exp_lat);
    check_eq({tag, "_lo"}, div_if.resultLow, exp_lo);
    check_eq({tag, "_hi"}, div_if.resultHigh, exp_hi);
    check_eq({tag, "_dz"}, {31'd0, div_if.DivZero}, {31'd0, exp_zero});
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'd0, div_if.DivOut}, 32'd0);
    check_eq({tag, "_hold"}, div_if.resultLow, exp_lo);
  endtask

  initial begin
    int edges;
    int pulses;
    n_checks      = 0;
    n_errors      = 0;
    Reset         = 1'b1;
    div_if.DivIn  = 1'b0;
    div_if.Signed = 1'b0;
    div_if.A      = '0;
    div_if.B      = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_lo", div_if.resultLow, 32'd0);
    check_eq("rst_hi", div_if.resultHigh, 32'd0);
    check_eq("rst_done", {31'd0, div_if.DivOut}, 32'd0);
    check_eq("rst_dz", {31'd0, div_if.DivZero}, 32'd0);
    Reset = 1'b0;

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    do_div("divu_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
    do_div("divu_max_16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    do_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);
    do_div("div_5_0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    do_div("divu_100_7_b", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    do_div("divu_3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, EarlyLat);
    do_div("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0, EarlyLat);

    // Reset at edge 10 of an operation: everything cleared, no done pulse.
    start(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check_eq("midrst_lo", div_if.resultLow, 32'd0);
    check_eq("midrst_hi", div_if.resultHigh, 32'd0);
    check_eq("midrst_dz", {31'd0, div_if.DivZero}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_if.DivOut) pulses++;
    end
    check_eq("midrst_pulses", pulses, 0);

    // Restart at edge 10 with 9/3: the only done pulse carries the new result.
    start(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    div_if.A     = 32'd9;
    div_if.B     = 32'd3;
    div_if.DivIn = 1'b1;
    @(negedge clk);
    div_if.DivIn = 1'b0;
    wait_done(edges);
    check_eq("abort_lat", edges, 33);
    check_eq("abort_lo", div_if.resultLow, 32'd3);
    check_eq("abort_hi", div_if.resultHigh, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_if.DivOut) pulses++;
    end
    check_eq("abort_extra_pulses", pulses, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
